// File: rtl/operand_sequencer.sv
// Operand sequencer: splits one instruction's operand text into per-slot tokens, streams each
// token to the register or immediate interpreter and collects the results into rd/rs1/rs2/imm.
module operand_sequencer #(
  parameter int WAIT_LIMIT = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start,
  input  logic [2:0]  fmt,
  input  logic        char_valid,
  output logic        char_ready,
  input  logic [7:0]  incoming_ascii,
  output logic        reg_valid,
  output logic        imm_valid,
  output logic        new_character,
  output logic [7:0]  fwd_ascii,
  output logic        imm_isUtype,
  input  logic        reg_done,
  input  logic        reg_error,
  input  logic [4:0]  reg_index,
  input  logic        imm_done,
  input  logic        imm_error,
  input  logic [31:0] imm_value,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] imm,
  output logic        op_done,
  output logic        op_error,
  output logic [1:0]  err_code
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_WAIT,
    S_GAP,
    S_DONE,
    S_ERROR
  } state_e;

  typedef enum logic [1:0] {
    F_RD,
    F_RS1,
    F_RS2,
    F_IMM
  } field_e;

  typedef enum logic [1:0] {
    E_NONE,
    E_INTERP,
    E_TIMEOUT,
    E_BAD_FMT
  } err_e;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [7:0] ASCII_SP    = 8'h20;
  localparam logic [7:0] ASCII_COMMA = 8'h2C;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  localparam int CNT_W = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

  // Which operand field a given slot of a given format fills.
  function automatic field_e slot_field(input logic [2:0] f, input logic [1:0] s);
    field_e fld;
    fld = F_IMM;
    case (f)
      FMT_R: fld = (s == 2'd0) ? F_RD  : (s == 2'd1) ? F_RS1 : F_RS2;
      FMT_I: fld = (s == 2'd0) ? F_RD  : (s == 2'd1) ? F_RS1 : F_IMM;
      FMT_S: fld = (s == 2'd0) ? F_RS2 : (s == 2'd1) ? F_RS1 : F_IMM;
      FMT_B: fld = (s == 2'd0) ? F_RS1 : (s == 2'd1) ? F_RS2 : F_IMM;
      FMT_U,
      FMT_J: fld = (s == 2'd0) ? F_RD  : F_IMM;
      default: fld = F_IMM;
    endcase
    return fld;
  endfunction

  function automatic logic slot_is_last(input logic [2:0] f, input logic [1:0] s);
    return ((f == FMT_U) || (f == FMT_J)) ? (s == 2'd1) : (s == 2'd2);
  endfunction

  state_e           state_q, state_d;
  logic [2:0]       fmt_q, fmt_d;
  logic [1:0]       slot_q, slot_d;
  logic             body_seen_q, body_seen_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       rd_q, rd_d;
  logic [4:0]       rs1_q, rs1_d;
  logic [4:0]       rs2_q, rs2_d;
  logic [31:0]      imm_q, imm_d;
  err_e             err_q, err_d;

  field_e           cur_field;
  logic             sel_imm;
  logic             sel_done;
  logic             sel_error;
  logic             xfer;
  logic             is_delim;
  logic             fwd;
  logic [CNT_W-1:0] cnt_inc;

  assign cur_field = slot_field(fmt_q, slot_q);
  assign sel_imm   = (cur_field == F_IMM);
  assign sel_done  = sel_imm ? imm_done  : reg_done;
  assign sel_error = sel_imm ? imm_error : reg_error;
  assign cnt_inc   = cnt_q + CNT_W'(1);

  assign char_ready = (state_q == S_RUN);
  assign xfer       = char_valid && char_ready;
  assign is_delim   = (incoming_ascii == ASCII_SP) || (incoming_ascii == ASCII_COMMA) ||
                      (incoming_ascii == ASCII_LF);
  // Leading delimiters are swallowed; the first delimiter after body text terminates the token.
  assign fwd        = xfer && (!is_delim || body_seen_q);

  assign new_character = fwd;
  assign fwd_ascii     = !fwd                        ? 8'h00    :
                         (incoming_ascii == ASCII_LF) ? ASCII_SP : incoming_ascii;

  assign reg_valid   = ((state_q == S_RUN) || (state_q == S_WAIT)) && !sel_imm;
  assign imm_valid   = ((state_q == S_RUN) || (state_q == S_WAIT)) &&  sel_imm;
  assign imm_isUtype = (fmt_q == FMT_U);
  assign op_done     = (state_q == S_DONE);
  assign op_error    = (state_q == S_ERROR);
  assign err_code    = err_q;
  assign rd          = rd_q;
  assign rs1         = rs1_q;
  assign rs2         = rs2_q;
  assign imm         = imm_q;

  always_comb begin
    // NOTE: every *_d starts as its *_q so no path through this block can infer a latch.
    state_d     = state_q;
    fmt_d       = fmt_q;
    slot_d      = slot_q;
    body_seen_d = body_seen_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    imm_d       = imm_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          fmt_d       = fmt;
          slot_d      = 2'd0;
          body_seen_d = 1'b0;
          cnt_d       = '0;
          rd_d        = '0;
          rs1_d       = '0;
          rs2_d       = '0;
          imm_d       = '0;
          if (fmt > FMT_J) begin
            state_d = S_ERROR;
            err_d   = E_BAD_FMT;
          end else begin
            state_d = S_RUN;
            err_d   = E_NONE;
          end
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        if (sel_error) begin
          state_d = S_ERROR;
          err_d   = E_INTERP;
        end else if (xfer) begin
          if (!is_delim) begin
            body_seen_d = 1'b1;
          end else if (body_seen_q) begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end
        end
      end

      S_WAIT: begin
        if (sel_error) begin
          state_d = S_ERROR;
          err_d   = E_INTERP;
        end else if (sel_done) begin
          case (cur_field)
            F_RD:    rd_d  = reg_index;
            F_RS1:   rs1_d = reg_index;
            F_RS2:   rs2_d = reg_index;
            default: imm_d = imm_value;
          endcase
          if (slot_is_last(fmt_q, slot_q)) begin
            state_d = S_DONE;
          end else begin
            slot_d      = slot_q + 2'd1;
            body_seen_d = 1'b0;
            state_d     = S_GAP;
          end
        end else if (cnt_inc == LIMIT) begin
          state_d = S_ERROR;
          err_d   = E_TIMEOUT;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      // One cycle with valid low returns the interpreter to its idle state before the next token.
      S_GAP: state_d = S_RUN;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments and resets asynchronously, so a mid-operation
  // reset drops every output to zero without waiting for a clock edge.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= S_IDLE;
      fmt_q       <= '0;
      slot_q      <= '0;
      body_seen_q <= 1'b0;
      cnt_q       <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      err_q       <= E_NONE;
    end else begin
      state_q     <= state_d;
      fmt_q       <= fmt_d;
      slot_q      <= slot_d;
      body_seen_q <= body_seen_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      imm_q       <= imm_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_operand_sequencer.sv
// Scoreboard bench for operand_sequencer: a tokenizer/schedule model predicts forwarded
// characters and final operand fields; a monitor compares them as the DUT presents them.
module tb_operand_sequencer;

  localparam int WAIT_LIMIT = 3;

  logic        clk_in;
  logic        rst_in;
  logic        start;
  logic [2:0]  fmt;
  logic        char_valid;
  logic        char_ready;
  logic [7:0]  incoming_ascii;
  logic        reg_valid;
  logic        imm_valid;
  logic        new_character;
  logic [7:0]  fwd_ascii;
  logic        imm_isUtype;
  logic        reg_done;
  logic        reg_error;
  logic [4:0]  reg_index;
  logic        imm_done;
  logic        imm_error;
  logic [31:0] imm_value;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic        op_done;
  logic        op_error;
  logic [1:0]  err_code;

  operand_sequencer #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .start          (start),
    .fmt            (fmt),
    .char_valid     (char_valid),
    .char_ready     (char_ready),
    .incoming_ascii (incoming_ascii),
    .reg_valid      (reg_valid),
    .imm_valid      (imm_valid),
    .new_character  (new_character),
    .fwd_ascii      (fwd_ascii),
    .imm_isUtype    (imm_isUtype),
    .reg_done       (reg_done),
    .reg_error      (reg_error),
    .reg_index      (reg_index),
    .imm_done       (imm_done),
    .imm_error      (imm_error),
    .imm_value      (imm_value),
    .rd             (rd),
    .rs1            (rs1),
    .rs2            (rs2),
    .imm            (imm),
    .op_done        (op_done),
    .op_error       (op_error),
    .err_code       (err_code)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // One interpreter reply per token: value, cycles in WAIT before replying, error flags.
  typedef struct {
    logic [31:0] value;
    int          lat;
    bit          err;
    bit          both;
  } resp_t;

  typedef struct packed {
    logic        is_err;
    logic [1:0]  code;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } result_t;

  // Field filled by each slot: 0=rd 1=rs1 2=rs2 3=imm, rows indexed by fmt.
  int sched [6][3] = '{'{0, 1, 2}, '{0, 1, 3}, '{2, 1, 3}, '{1, 2, 3}, '{0, 3, -1}, '{0, 3, -1}};

  resp_t        resp_q[$];
  byte unsigned stream[$];
  byte unsigned exp_chars[$];
  result_t      exp_res[$];
  int           checks = 0;
  int           fails  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    checks++;
    fails++;
    $display("FAIL %s: event seen where none was expected", name);
  endtask

  function automatic logic [63:0] all_outputs();
    return {char_ready, reg_valid, imm_valid, new_character, fwd_ascii, imm_isUtype,
            rd, rs1, rs2, imm, op_done, op_error, err_code};
  endfunction

  // ---------------- reference model ----------------
  task automatic model_chars();
    bit body = 1'b0;
    foreach (stream[i]) begin
      byte unsigned c = stream[i];
      bit delim = (c == 8'h20) || (c == 8'h2C) || (c == 8'h0A);
      if (!delim) begin
        exp_chars.push_back(c);
        body = 1'b1;
      end else if (body) begin
        exp_chars.push_back((c == 8'h0A) ? 8'h20 : c);
        body = 1'b0;
      end
    end
  endtask

  task automatic model_result(input logic [2:0] f);
    result_t r = '0;
    int n;
    if (f > 3'd5) begin
      r.is_err = 1'b1;
      r.code   = 2'd3;
      exp_res.push_back(r);
      return;
    end
    n = (f >= 3'd4) ? 2 : 3;
    for (int i = 0; i < resp_q.size(); i++) begin
      if (resp_q[i].err) begin
        r.is_err = 1'b1;
        r.code   = 2'd1;
        exp_res.push_back(r);
        return;
      end
      if (resp_q[i].lat >= WAIT_LIMIT) begin
        r.is_err = 1'b1;
        r.code   = 2'd2;
        exp_res.push_back(r);
        return;
      end
      case (sched[int'(f)][i])
        0:       r.rd  = resp_q[i].value[4:0];
        1:       r.rs1 = resp_q[i].value[4:0];
        2:       r.rs2 = resp_q[i].value[4:0];
        default: r.imm = resp_q[i].value;
      endcase
      if (i == n - 1) begin
        exp_res.push_back(r);
        return;
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) stream.push_back(s[i]);
  endtask

  task automatic add_resp(input logic [31:0] value, input int lat, input bit err, input bit both);
    resp_t r;
    r.value = value;
    r.lat   = lat;
    r.err   = err;
    r.both  = both;
    resp_q.push_back(r);
  endtask

  // Called just after a falling edge; returns on the falling edge after the character is taken.
  task automatic send_char(input byte unsigned c);
    bit took = 1'b0;
    int guard = 0;
    char_valid     = 1'b1;
    incoming_ascii = c;
    while (!took && guard < 40) begin
      took = char_ready;
      @(negedge clk_in);
      guard++;
    end
    char_valid     = 1'b0;
    incoming_ascii = 8'($urandom);
    if (!took) flag_fail("char_stall");
  endtask

  task automatic run_op(input logic [2:0] f, input int inject_at, input bit watch_wait);
    int guard = 0;
    int n     = 0;
    model_chars();
    model_result(f);
    start = 1'b1;
    fmt   = f;
    @(negedge clk_in);
    start = 1'b0;
    fmt   = 3'($urandom);
    foreach (stream[i]) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk_in);
      if (i == inject_at) begin
        start = 1'b1;
        fmt   = 3'd7;
      end
      send_char(stream[i]);
      start = 1'b0;
    end
    if (watch_wait) begin
      while (!op_error && n < 20) begin
        check("wait_char_ready", {63'd0, char_ready}, 64'd0);
        n++;
        @(negedge clk_in);
      end
      check("wait_cycles", 64'(n), 64'(WAIT_LIMIT));
    end
    while ((exp_res.size() > 0 || exp_chars.size() > 0) && guard < 60) begin
      @(negedge clk_in);
      guard++;
    end
    if (exp_res.size() > 0) flag_fail("op_completion_timeout");
    check("chars_outstanding", 64'(exp_chars.size()), 64'd0);
    exp_res.delete();
    exp_chars.delete();
    resp_q.delete();
    stream.delete();
    repeat ($urandom_range(1, 3)) @(negedge clk_in);
  endtask

  task automatic build_random(output logic [2:0] f);
    string        alnum = "abcstx0123456789";
    byte unsigned delims [3] = '{8'h20, 8'h2C, 8'h0A};
    resp_t        r;
    int           n;
    int           len;
    int           roll;
    if ($urandom_range(0, 15) == 0) begin
      f = 3'($urandom_range(6, 7));
      return;
    end
    f = 3'($urandom_range(0, 5));
    n = (f >= 3'd4) ? 2 : 3;
    for (int i = 0; i < n; i++) begin
      len = int'($urandom_range(0, 2));
      for (int k = 0; k < len; k++) stream.push_back(delims[$urandom_range(0, 2)]);
      len = int'($urandom_range(1, 4));
      for (int k = 0; k < len; k++) stream.push_back(alnum[int'($urandom_range(0, 15))]);
      stream.push_back(delims[$urandom_range(0, 2)]);
      r.value = $urandom;
      r.lat   = int'($urandom_range(0, WAIT_LIMIT - 1));
      r.err   = 1'b0;
      r.both  = 1'b0;
      roll    = int'($urandom_range(0, 19));
      if (roll == 0) r.err = 1'b1;
      else if (roll == 1) begin
        r.err  = 1'b1;
        r.both = 1'b1;
      end else if (roll == 2) r.lat = WAIT_LIMIT + 4;
      resp_q.push_back(r);
      if (r.err || r.lat >= WAIT_LIMIT) break;
    end
  endtask

  // ---------------- interpreter responder ----------------
  initial begin
    int  wcnt = 0;
    bit  in_wait;
    resp_t r;
    reg_done  = 1'b0;
    reg_error = 1'b0;
    reg_index = '0;
    imm_done  = 1'b0;
    imm_error = 1'b0;
    imm_value = '0;
    forever begin
      @(negedge clk_in);
      reg_done  = 1'b0;
      reg_error = 1'b0;
      imm_done  = 1'b0;
      imm_error = 1'b0;
      reg_index = 5'($urandom);
      imm_value = $urandom;
      in_wait   = rst_in && (reg_valid || imm_valid) && !char_ready;
      if (!in_wait) begin
        wcnt = 0;
      end else begin
        if (resp_q.size() > 0 && wcnt == resp_q[0].lat) begin
          r = resp_q.pop_front();
          if (reg_valid) begin
            reg_error = r.err;
            reg_done  = !r.err || r.both;
            reg_index = r.value[4:0];
          end else begin
            imm_error = r.err;
            imm_done  = !r.err || r.both;
            imm_value = r.value;
          end
        end
        wcnt++;
        // Stray strobes from the interpreter that is not selected.
        if (reg_valid) begin
          imm_done  = ($urandom_range(0, 2) == 0);
          imm_error = ($urandom_range(0, 6) == 0);
        end else begin
          reg_done  = ($urandom_range(0, 2) == 0);
          reg_error = ($urandom_range(0, 6) == 0);
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    bit prev_err   = 1'b0;
    bit start_seen = 1'b0;
    result_t act;
    forever begin
      @(negedge clk_in);
      #2;
      if (new_character) begin
        if (exp_chars.size() == 0) flag_fail("unexpected_char");
        else check("fwd_ascii", 64'(fwd_ascii), 64'(exp_chars.pop_front()));
      end
      act = {1'b0, err_code, rd, rs1, rs2, imm};
      if (op_done) begin
        if (exp_res.size() == 0) flag_fail("unexpected_op_done");
        else check("op_done_result", 64'(act), 64'(exp_res.pop_front()));
      end
      if (op_error && (!prev_err || start_seen)) begin
        act.is_err = 1'b1;
        if (exp_res.size() == 0) flag_fail("unexpected_op_error");
        else check("op_error_result", 64'(act), 64'(exp_res.pop_front()));
      end
      prev_err   = op_error;
      start_seen = start;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [2:0] f;
    rst_in         = 1'b0;
    start          = 1'b0;
    fmt            = 3'd0;
    char_valid     = 1'b0;
    incoming_ascii = 8'h00;
    #2;
    check("reset_outputs", all_outputs(), 64'd0);
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);

    // I-type with replies at every latency up to the last legal WAIT cycle.
    push_str("a0,sp,0x7FF\n");
    add_resp(32'd10, 0, 1'b0, 1'b0);
    add_resp(32'd2, 1, 1'b0, 1'b0);
    add_resp(32'h7FF, WAIT_LIMIT - 1, 1'b0, 1'b0);
    run_op(3'd1, -1, 1'b0);
    check("imm_isUtype_I", {63'd0, imm_isUtype}, 64'd0);

    // U-type with leading/duplicate delimiters and LF terminator.
    push_str("  t0 , 0xFFFFF\n");
    add_resp(32'd5, 1, 1'b0, 1'b0);
    add_resp(32'h000FFFFF, 0, 1'b0, 1'b0);
    run_op(3'd4, -1, 1'b0);
    check("imm_isUtype_U", {63'd0, imm_isUtype}, 64'd1);

    // R-type: rs2 reply raises error and done together.
    push_str("x1,x2,x3\n");
    add_resp(32'd1, 0, 1'b0, 1'b0);
    add_resp(32'd2, 2, 1'b0, 1'b0);
    add_resp(32'd3, 1, 1'b1, 1'b1);
    run_op(3'd0, -1, 1'b0);

    // Recovery, with a bad-fmt start pulsed while RUN that must be ignored.
    push_str("x4 x5 x6\n");
    add_resp(32'd4, 0, 1'b0, 1'b0);
    add_resp(32'd5, 0, 1'b0, 1'b0);
    add_resp(32'd6, 0, 1'b0, 1'b0);
    run_op(3'd0, 1, 1'b0);

    // Silent interpreter: timeout after WAIT_LIMIT cycles with char_ready low.
    push_str("x9,");
    add_resp(32'd9, WAIT_LIMIT + 4, 1'b0, 1'b0);
    run_op(3'd2, -1, 1'b1);

    // Invalid formats, back to back.
    run_op(3'd7, -1, 1'b0);
    run_op(3'd6, -1, 1'b0);

    // Reset asserted mid-WAIT after one field has been captured.
    push_str("a0,sp,");
    add_resp(32'd10, 0, 1'b0, 1'b0);
    add_resp(32'd2, WAIT_LIMIT + 4, 1'b0, 1'b0);
    model_chars();
    start = 1'b1;
    fmt   = 3'd1;
    @(negedge clk_in);
    start = 1'b0;
    foreach (stream[i]) send_char(stream[i]);
    #1;
    rst_in = 1'b0;
    #1;
    check("reset_mid_wait", all_outputs(), 64'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    check("reset_chars_outstanding", 64'(exp_chars.size()), 64'd0);
    exp_chars.delete();
    resp_q.delete();
    stream.delete();
    @(negedge clk_in);

    // First operation after reset behaves as from power-up.
    push_str("a0,sp,0x7FF\n");
    add_resp(32'd10, 1, 1'b0, 1'b0);
    add_resp(32'd2, 0, 1'b0, 1'b0);
    add_resp(32'h7FF, 2, 1'b0, 1'b0);
    run_op(3'd1, -1, 1'b0);

    for (int t = 0; t < 40; t++) begin
      build_random(f);
      run_op(f, -1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
